pb_gpio_irq: RTL and testbench

- Parametrised PicoBlaze GPIO peripheral; next generation of the 8-bit GPIO block.
- Width scales in byte lanes. Each pin has direction control, output data, and atomic set/clear.
- Adds two-flop input synchronisers and per-pin rising/falling edge interrupts, with mask and write-1-to-clear status.
- Sits on the PicoBlaze port bus (port_id/strobes) and drives a single level interrupt to the CPU.

---
 rtl/pb_gpio_irq_pkg.sv | 30 +++
 rtl/pb_gpio_irq_sync_edge.sv | 33 +++
 rtl/pb_gpio_irq.sv | 145 ++++++++++++++
 tb/tb_pb_gpio_irq.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pb_gpio_irq_pkg.sv
// Shared register map and address helpers for the PicoBlaze GPIO/interrupt block.
package pb_gpio_irq_pkg;

    // Register offsets inside one 16-port lane window.
    typedef enum logic [3:0] {
        REG_DIN   = 4'd0,
        REG_DOUT  = 4'd1,
        REG_OEN   = 4'd2,
        REG_SET   = 4'd3,
        REG_CLR   = 4'd4,
        REG_IMASK = 4'd5,
        REG_RISE  = 4'd6,
        REG_FALL  = 4'd7,
        REG_ISTAT = 4'd8
    } reg_off_e;

    localparam int         LANE_STRIDE   = 16;
    localparam int         LANE_BITS     = 8;
    localparam logic [7:0] RESERVED_READ = 8'h00;

    // True when addr falls inside the block's window of lanes*16 ports.
    function automatic logic addr_in_block(input logic [7:0] addr,
                                           input logic [7:0] base,
                                           input int         lanes);
        int rel;
        rel = int'(addr) - int'(base);
        return (rel >= 0) && (rel < LANE_STRIDE * lanes);
    endfunction

endpackage

// File: rtl/pb_gpio_irq_sync_edge.sv
// One byte lane of pad input conditioning: two-flop synchroniser plus a
// history flop so rising/falling edges can be seen on the synchronised value.
module gpio_sync_edge (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] pad,
    output logic [7:0] sync,
    output logic [7:0] rise,
    output logic [7:0] fall
);

    logic [7:0] s1;
    logic [7:0] s2;
    logic [7:0] s3;

    // Synchroniser chain; s3 holds the previous synchronised value for edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1 <= 8'h00;
            s2 <= 8'h00;
            s3 <= 8'h00;
        end else begin
            s1 <= pad;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign sync = s2;
    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;

endmodule

// File: rtl/pb_gpio_irq.sv
// PicoBlaze GPIO peripheral with per-pin direction, atomic set/clear and
// edge-triggered, maskable, write-1-to-clear interrupts. Scales in byte lanes.
module pb_gpio_irq
    import pb_gpio_irq_pkg::*;
#(
    parameter int         GPIO_WIDTH        = 8,
    parameter logic [7:0] GPIO_BASE_ADDRESS = 8'h00
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            port_id,
    input  logic [7:0]            data_in,
    input  logic                  read_strobe,
    input  logic                  write_strobe,
    output logic [7:0]            data_out,
    output logic                  interrupt,
    inout  wire  [GPIO_WIDTH-1:0] gpio
);

    localparam int LANES = GPIO_WIDTH / LANE_BITS;

    // Reads have no side effects, so the read qualifier is not needed.
    logic unused_read_strobe;
    assign unused_read_strobe = read_strobe;

    logic                  in_block;
    logic [3:0]            lane_sel;
    reg_off_e              offset;
    logic [7:0]            rd_val;

    logic [GPIO_WIDTH-1:0] din_v;
    logic [GPIO_WIDTH-1:0] dout_v;
    logic [GPIO_WIDTH-1:0] oen_v;
    logic [GPIO_WIDTH-1:0] imask_v;
    logic [GPIO_WIDTH-1:0] rise_v;
    logic [GPIO_WIDTH-1:0] fall_v;
    logic [GPIO_WIDTH-1:0] istat_v;

    // Lane index relative to the base; only meaningful while in_block is set.
    assign in_block = addr_in_block(port_id, GPIO_BASE_ADDRESS, LANES);
    assign lane_sel = port_id[7:4] - GPIO_BASE_ADDRESS[7:4];
    assign offset   = reg_off_e'(port_id[3:0]);

    for (genvar n = 0; n < LANES; n++) begin : g_lane
        logic [7:0] dout_q;
        logic [7:0] oen_q;
        logic [7:0] imask_q;
        logic [7:0] rise_q;
        logic [7:0] fall_q;
        logic [7:0] istat_q;
        logic [7:0] din;
        logic [7:0] rise_ev;
        logic [7:0] fall_ev;
        logic [7:0] w1c;
        logic       wr_hit;

        assign wr_hit = write_strobe && in_block && (lane_sel == 4'(n));
        assign w1c    = (wr_hit && offset == REG_ISTAT) ? data_in : 8'h00;

        gpio_sync_edge u_sync (
            .clk   (clk),
            .reset (reset),
            .pad   (gpio[8*n +: 8]),
            .sync  (din),
            .rise  (rise_ev),
            .fall  (fall_ev)
        );

        // Writable control registers of this lane; SET/CLR modify DOUT in place.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                dout_q  <= 8'h00;
                oen_q   <= 8'h00;
                imask_q <= 8'h00;
                rise_q  <= 8'h00;
                fall_q  <= 8'h00;
            end else if (wr_hit) begin
                case (offset)
                    REG_DOUT:  dout_q  <= data_in;
                    REG_OEN:   oen_q   <= data_in;
                    REG_SET:   dout_q  <= dout_q | data_in;
                    REG_CLR:   dout_q  <= dout_q & ~data_in;
                    REG_IMASK: imask_q <= data_in;
                    REG_RISE:  rise_q  <= data_in;
                    REG_FALL:  fall_q  <= data_in;
                    default:   ;
                endcase
            end
        end

        // Interrupt status: a new enabled edge wins over a same-cycle clear.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                istat_q <= 8'h00;
            end else begin
                istat_q <= (istat_q & ~w1c) | (rise_ev & rise_q) | (fall_ev & fall_q);
            end
        end

        for (genvar b = 0; b < LANE_BITS; b++) begin : g_pad
            assign gpio[8*n + b] = oen_q[b] ? dout_q[b] : 1'bz;
        end

        assign din_v[8*n +: 8]   = din;
        assign dout_v[8*n +: 8]  = dout_q;
        assign oen_v[8*n +: 8]   = oen_q;
        assign imask_v[8*n +: 8] = imask_q;
        assign rise_v[8*n +: 8]  = rise_q;
        assign fall_v[8*n +: 8]  = fall_q;
        assign istat_v[8*n +: 8] = istat_q;
    end

    // Read mux; write-only, reserved and out-of-window ports return the reserved value.
    always_comb begin
        rd_val = RESERVED_READ;
        if (in_block) begin
            for (int n = 0; n < LANES; n++) begin
                if (lane_sel == 4'(n)) begin
                    case (offset)
                        REG_DIN:   rd_val = din_v[8*n +: 8];
                        REG_DOUT:  rd_val = dout_v[8*n +: 8];
                        REG_OEN:   rd_val = oen_v[8*n +: 8];
                        REG_IMASK: rd_val = imask_v[8*n +: 8];
                        REG_RISE:  rd_val = rise_v[8*n +: 8];
                        REG_FALL:  rd_val = fall_v[8*n +: 8];
                        REG_ISTAT: rd_val = istat_v[8*n +: 8];
                        default:   rd_val = RESERVED_READ;
                    endcase
                end
            end
        end
    end

    // Registered read data and level interrupt.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_out  <= 8'h00;
            interrupt <= 1'b0;
        end else begin
            data_out  <= rd_val;
            interrupt <= |(istat_v & imask_v);
        end
    end

endmodule

// File: tb/tb_pb_gpio_irq.sv
// Bench for pb_gpio_irq: a 16-pin instance at 0x20 exercised with directed and
// random traffic, plus a 32-pin instance at 0x80 for decode/default reads.
module tb_pb_gpio_irq;

    localparam int         W     = 16;
    localparam int         LANES = W / 8;
    localparam logic [7:0] BASE  = 8'h20;
    localparam int         W2    = 32;
    localparam logic [7:0] BASE2 = 8'h80;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [7:0]    port_id = 8'h00;
    logic [7:0]    data_in = 8'h00;
    logic          read_strobe = 1'b0;
    logic          write_strobe = 1'b0;
    logic [7:0]    data_out;
    logic [7:0]    data_out2;
    logic          interrupt;
    logic          interrupt2;
    wire  [W-1:0]  gpio;
    wire  [W2-1:0] gpio2;
    logic [W-1:0]  drv = '0;
    logic [W2-1:0] drv2 = 32'h5A3C_96E1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Reference model state: register file plus the pad values seen at past edges.
    logic [W-1:0] m_dout, m_oen, m_imask, m_rise, m_fall, m_istat;
    logic [W-1:0] seen_1ago, seen_2ago, seen_3ago;
    logic         m_irq;
    logic         rd_pend;
    logic [7:0]   rdq[$];
    logic [7:0]   rdq2[$];

    pb_gpio_irq #(.GPIO_WIDTH(W), .GPIO_BASE_ADDRESS(BASE)) dut (
        .clk(clk), .reset(reset), .port_id(port_id), .data_in(data_in),
        .read_strobe(read_strobe), .write_strobe(write_strobe),
        .data_out(data_out), .interrupt(interrupt), .gpio(gpio)
    );

    pb_gpio_irq #(.GPIO_WIDTH(W2), .GPIO_BASE_ADDRESS(BASE2)) dut2 (
        .clk(clk), .reset(reset), .port_id(port_id), .data_in(data_in),
        .read_strobe(read_strobe), .write_strobe(write_strobe),
        .data_out(data_out2), .interrupt(interrupt2), .gpio(gpio2)
    );

    // The bench drives every pad the DUT is not supposed to drive.
    for (genvar i = 0; i < W; i++) begin : g_tbdrv
        assign gpio[i] = m_oen[i] ? 1'bz : drv[i];
    end
    for (genvar i = 0; i < W2; i++) begin : g_tbdrv2
        assign gpio2[i] = drv2[i];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected read of the 16-pin block, from the register file and pin history.
    function automatic logic [7:0] model_read(input logic [7:0] a);
        int rel, lane;
        rel = int'(a) - int'(BASE);
        if (rel < 0 || rel >= 16 * LANES) return 8'h00;
        lane = rel / 16;
        case (rel % 16)
            0: return seen_2ago[8*lane +: 8];
            1: return m_dout[8*lane +: 8];
            2: return m_oen[8*lane +: 8];
            5: return m_imask[8*lane +: 8];
            6: return m_rise[8*lane +: 8];
            7: return m_fall[8*lane +: 8];
            8: return m_istat[8*lane +: 8];
            default: return 8'h00;
        endcase
    endfunction

    // Expected read of the untouched 32-pin block: only DIN is non-zero.
    function automatic logic [7:0] model_read2(input logic [7:0] a);
        int rel;
        rel = int'(a) - int'(BASE2);
        if (rel < 0 || rel >= 64 || (rel % 16) != 0) return 8'h00;
        return drv2[8*(rel/16) +: 8];
    endfunction

    // Reference model, advanced once per clock edge.
    always @(posedge clk or negedge reset) begin
        logic [W-1:0] ev, w1c, pad_now;
        int rel, lane;
        if (!reset) begin
            m_dout = '0; m_oen = '0; m_imask = '0; m_rise = '0; m_fall = '0; m_istat = '0;
            seen_1ago = '0; seen_2ago = '0; seen_3ago = '0;
            m_irq = 1'b0; rd_pend = 1'b0;
            rdq.delete(); rdq2.delete();
        end else begin
            rd_pend = read_strobe;
            if (read_strobe) begin
                rdq.push_back(model_read(port_id));
                rdq2.push_back(model_read2(port_id));
            end
            m_irq   = |(m_istat & m_imask);
            ev      = (seen_2ago & ~seen_3ago & m_rise) | (~seen_2ago & seen_3ago & m_fall);
            pad_now = (m_oen & m_dout) | (~m_oen & drv);
            w1c     = '0;
            rel     = int'(port_id) - int'(BASE);
            if (write_strobe && rel >= 0 && rel < 16 * LANES) begin
                lane = rel / 16;
                case (rel % 16)
                    1: m_dout[8*lane +: 8]  = data_in;
                    2: m_oen[8*lane +: 8]   = data_in;
                    3: m_dout[8*lane +: 8]  = m_dout[8*lane +: 8] | data_in;
                    4: m_dout[8*lane +: 8]  = m_dout[8*lane +: 8] & ~data_in;
                    5: m_imask[8*lane +: 8] = data_in;
                    6: m_rise[8*lane +: 8]  = data_in;
                    7: m_fall[8*lane +: 8]  = data_in;
                    8: w1c[8*lane +: 8]     = data_in;
                    default: ;
                endcase
            end
            m_istat   = (m_istat & ~w1c) | ev;
            seen_3ago = seen_2ago;
            seen_2ago = seen_1ago;
            seen_1ago = pad_now;
        end
    end

    // Monitor: compares outputs every cycle and pops read expectations.
    always @(negedge clk) begin
        if (reset) begin
            chk("irq", 32'(interrupt), 32'(m_irq));
            chk("irq2", 32'(interrupt2), 32'h0);
            chk("pads_driven", 32'(gpio & m_oen), 32'(m_dout & m_oen));
            if (rd_pend) begin
                if (rdq.size() == 0 || rdq2.size() == 0) begin
                    chk("rdq_underflow", 32'h1, 32'h0);
                end else begin
                    chk("rdata", 32'(data_out), 32'(rdq.pop_front()));
                    chk("rdata2", 32'(data_out2), 32'(rdq2.pop_front()));
                end
            end
        end
    end

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        port_id = a; data_in = d; write_strobe = 1'b1;
        @(negedge clk);
        write_strobe = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a);
        port_id = a; read_strobe = 1'b1;
        @(negedge clk);
        read_strobe = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        idle(3);
        reset = 1'b1;
        idle(1);
        chk("reset_dout", 32'(data_out), 32'h0);
        chk("reset_irq", 32'(interrupt), 32'h0);
        idle(4);

        // Output path on lane 1, lane 0 left as input.
        wr(8'h32, 8'hFF);
        wr(8'h31, 8'hA5);
        chk("gpio_hi_a5", 32'(gpio[15:8]), 32'hA5);
        wr(8'h33, 8'h0A);
        chk("gpio_hi_set", 32'(gpio[15:8]), 32'hAF);
        wr(8'h34, 8'h81);
        chk("gpio_hi_clr", 32'(gpio[15:8]), 32'h2E);
        drv[7:0] = 8'h3C;
        idle(3);
        rd(8'h20);
        chk("din_lane0_undriven", 32'(data_out), 32'h3C);
        rd(8'h30);
        chk("din_lane1_readback", 32'(data_out), 32'h2E);
        wr(8'h32, 8'h00);

        // Rising edge on pin 0 with exact interrupt latency.
        wr(8'h26, 8'h01);
        wr(8'h25, 8'h01);
        idle(4);
        wr(8'h28, 8'hFF);
        idle(2);
        drv[0] = 1'b1;
        idle(3);
        chk("rise_irq_early", 32'(interrupt), 32'h0);
        idle(1);
        chk("rise_irq", 32'(interrupt), 32'h1);
        rd(8'h28);
        chk("rise_istat", 32'(data_out), 32'h01);
        wr(8'h28, 8'h01);
        idle(1);
        chk("w1c_irq_clear", 32'(interrupt), 32'h0);

        // Both edges on pin 15, then mask it off.
        wr(8'h37, 8'h80);
        wr(8'h36, 8'h80);
        idle(3);
        wr(8'h38, 8'hFF);
        drv[15] = 1'b1;
        idle(4);
        drv[15] = 1'b0;
        idle(4);
        rd(8'h38);
        chk("both_istat", 32'(data_out), 32'h80);
        wr(8'h35, 8'h80);
        idle(1);
        chk("both_irq", 32'(interrupt), 32'h1);
        wr(8'h35, 8'h00);
        idle(1);
        chk("masked_irq", 32'(interrupt), 32'h0);
        rd(8'h38);
        chk("masked_istat_kept", 32'(data_out), 32'h80);

        // Clear of bit 0 lands in the same cycle as its new rising edge.
        drv[0] = 1'b0;
        idle(4);
        wr(8'h28, 8'h01);
        idle(2);
        drv[0] = 1'b1;
        idle(2);
        wr(8'h28, 8'h01);
        rd(8'h28);
        chk("collision_istat", 32'(data_out), 32'h01);
        chk("collision_irq", 32'(interrupt), 32'h1);
        idle(2);
        chk("collision_irq_hold", 32'(interrupt), 32'h1);

        // Reserved and out-of-range ports.
        for (int a = 8'h29; a <= 8'h30; a++) begin
            logic [7:0] pa;
            pa = (a == 8'h30) ? 8'h40 : 8'(a);
            wr(pa, 8'($urandom));
            rd(pa);
            chk("decode_zero", 32'(data_out), 32'h0);
        end

        // Random traffic against the model.
        for (int it = 0; it < 700; it++) begin
            int op;
            op = $urandom_range(0, 9);
            if (op <= 2)      wr(8'(BASE + 16 * $urandom_range(0, 2) + $urandom_range(0, 15)), 8'($urandom));
            else if (op <= 5) rd(8'(8'h18 + $urandom_range(0, 8'h37)));
            else if (op <= 7) begin drv = W'($urandom); idle(1); end
            else              idle($urandom_range(1, 4));
        end

        // Reset in the middle of operation with pads being driven.
        wr(8'h22, 8'hFF);
        wr(8'h21, 8'h5A);
        drv[7:0] = 8'hC3;
        idle(2);
        reset = 1'b0;
        #1;
        chk("midreset_dout", 32'(data_out), 32'h0);
        chk("midreset_irq", 32'(interrupt), 32'h0);
        chk("midreset_pads", 32'(gpio), 32'(drv));
        idle(2);
        reset = 1'b1;
        idle(4);
        for (int a = 8'h20; a < 8'h40; a++) rd(8'(a));
        for (int a = 8'h80; a <= 8'hC0; a++) rd(8'(a));
        rd(8'h20);
        chk("defaults_din_lane0", 32'(data_out), 32'(drv[7:0]));
        rd(8'hB0);
        chk("defaults2_din_lane3", 32'(data_out2), 32'(drv2[31:24]));
        idle(3);
        chk("rdq_drained", 32'(rdq.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
